// File: rtl/soc_reset_ctrl.sv
// SoC reset controller: synchronizes and debounces a reset push-button and sequences soc_reset_n.
// Optional long-press mode (short press pulses btn_short) is enabled by RESET_CTRL_LONG_PRESS_EN.
module soc_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int HOLD_CYCLES       = 1024,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       user_btn,
  output logic       soc_reset_n,
  output logic       btn_short,
  output logic [7:0] reset_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  // Counters are only wide enough for parameter values of 2 or more.
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_check
    $error("soc_reset_ctrl: cycle parameters must be >= 2");
  end

  typedef enum logic [1:0] {
    HOLD,
    RUN
`ifdef RESET_CTRL_LONG_PRESS_EN
    , PRESS
`endif
  } state_t;

  state_t          state, next_state;
  logic [1:0]      sync;
  logic            btn_sync;
  logic            btn_db;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold_cnt, hold_next;

  assign btn_sync = sync[1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync   <= 2'b11;
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], user_btn};
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef RESET_CTRL_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LP_MAX = LW'(LONG_PRESS_CYCLES - 1);
  logic [LW-1:0] press_cnt, press_next;
  logic          short_next;
`endif

  // RUN is only entered with btn_db high, so a low level in RUN is a fresh 1->0 edge.
  always_comb begin
    next_state = state;
    hold_next  = '0;
`ifdef RESET_CTRL_LONG_PRESS_EN
    press_next = '0;
    short_next = 1'b0;
`endif
    case (state)
      HOLD: begin
        if (btn_db) begin
          if (hold_cnt == HOLD_MAX) next_state = RUN;
          else                      hold_next  = hold_cnt + 1'b1;
        end
      end
      RUN: begin
`ifdef RESET_CTRL_LONG_PRESS_EN
        if (!btn_db) next_state = PRESS;
`else
        if (!btn_db) next_state = HOLD;
`endif
      end
`ifdef RESET_CTRL_LONG_PRESS_EN
      PRESS: begin
        if (btn_db) begin
          next_state = RUN;
          short_next = 1'b1;
        end else if (press_cnt == LP_MAX) begin
          next_state = HOLD;
        end else begin
          press_next = press_cnt + 1'b1;
        end
      end
`endif
      default: next_state = HOLD;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      soc_reset_n <= 1'b0;
      reset_count <= '0;
    end else begin
      state       <= next_state;
      hold_cnt    <= hold_next;
      soc_reset_n <= (next_state != HOLD);
      if (state != HOLD && next_state == HOLD && reset_count != 8'hFF)
        reset_count <= reset_count + 1'b1;
    end
  end

`ifdef RESET_CTRL_LONG_PRESS_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      press_cnt <= '0;
      btn_short <= 1'b0;
    end else begin
      press_cnt <= press_next;
      btn_short <= short_next;
    end
  end
`else
  assign btn_short = 1'b0;
`endif

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// Directed self-checking bench for soc_reset_ctrl with DEBOUNCE=4, HOLD=8, LONG_PRESS=16.
// Long-press steps are compiled in when RESET_CTRL_LONG_PRESS_EN is defined.
module tb_soc_reset_ctrl;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       user_btn;
  logic       soc_reset_n;
  logic       btn_short;
  logic [7:0] reset_count;

  int n_checks = 0;
  int n_pass   = 0;

  soc_reset_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .HOLD_CYCLES      (8),
    .LONG_PRESS_CYCLES(16)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .user_btn     (user_btn),
    .soc_reset_n  (soc_reset_n),
    .btn_short    (btn_short),
    .reset_count  (reset_count)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Bounded wait for soc_reset_n to reach a level; a timeout shows up as a failed check.
  task automatic wait_rst(input string tag, input logic val, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (soc_reset_n === val) break;
      tick(1);
    end
    chk(tag, {31'd0, soc_reset_n}, {31'd0, val});
  endtask

  initial begin
    reset_reset_n = 1'b0;
    user_btn      = 1'b1;
    #12;
    chk("rst_soc_reset_n", {31'd0, soc_reset_n}, 0);
    chk("rst_btn_short",   {31'd0, btn_short},   0);
    chk("rst_count",       {24'd0, reset_count}, 0);

    // Release reset just after an edge: rise on the 8th edge.
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    tick(7);
    chk("hold_edge7_low", {31'd0, soc_reset_n}, 0);
    tick(1);
    chk("hold_edge8_high", {31'd0, soc_reset_n}, 1);
    chk("hold_count0", {24'd0, reset_count}, 0);

    // 3-cycle bounce is rejected.
    user_btn = 1'b0;
    tick(3);
    user_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("bounce_stays_run", {31'd0, soc_reset_n}, 1);
    end
    chk("bounce_count0", {24'd0, reset_count}, 0);
    chk("bounce_no_short", {31'd0, btn_short}, 0);

`ifndef RESET_CTRL_LONG_PRESS_EN
    // Direct press: low on 7th edge, high 8 edges after btn_db returns.
    user_btn = 1'b0;
    tick(6);
    chk("press_edge6_high", {31'd0, soc_reset_n}, 1);
    tick(1);
    chk("press_edge7_low", {31'd0, soc_reset_n}, 0);
    chk("press_count1", {24'd0, reset_count}, 1);
    tick(13);
    chk("held_stays_low", {31'd0, soc_reset_n}, 0);
    user_btn = 1'b1;
    tick(13);
    chk("release_edge13_low", {31'd0, soc_reset_n}, 0);
    tick(1);
    chk("release_edge14_high", {31'd0, soc_reset_n}, 1);
    chk("release_count1", {24'd0, reset_count}, 1);
    chk("macro_off_short0", {31'd0, btn_short}, 0);
`else
    // Short press: btn_short pulses on edge 17, soc_reset_n stays high.
    user_btn = 1'b0;
    tick(10);
    user_btn = 1'b1;
    tick(6);
    chk("short_edge16_0", {31'd0, btn_short}, 0);
    tick(1);
    chk("short_edge17_1", {31'd0, btn_short}, 1);
    chk("short_run_high", {31'd0, soc_reset_n}, 1);
    tick(1);
    chk("short_edge18_0", {31'd0, btn_short}, 0);
    chk("short_count0", {24'd0, reset_count}, 0);
    tick(4);
    // Long press: HOLD on edge 23 (7 + 16).
    user_btn = 1'b0;
    tick(22);
    chk("long_edge22_high", {31'd0, soc_reset_n}, 1);
    tick(1);
    chk("long_edge23_low", {31'd0, soc_reset_n}, 0);
    chk("long_count1", {24'd0, reset_count}, 1);
    tick(17);
    user_btn = 1'b1;
    tick(13);
    chk("long_rel_edge13_low", {31'd0, soc_reset_n}, 0);
    tick(1);
    chk("long_rel_edge14_high", {31'd0, soc_reset_n}, 1);
    chk("long_rel_count1", {24'd0, reset_count}, 1);
`endif

    // 300 more button resets saturate the counter.
    for (int k = 0; k < 300; k++) begin
      user_btn = 1'b0;
      wait_rst("sat_press", 1'b0, 100);
      user_btn = 1'b1;
      wait_rst("sat_release", 1'b1, 100);
    end
    chk("sat_count255", {24'd0, reset_count}, 255);

    // Reset mid-HOLD with button held.
    user_btn = 1'b0;
    wait_rst("midhold_enter", 1'b0, 100);
    tick(3);
    chk("midhold_count255", {24'd0, reset_count}, 255);
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("midhold_async_count", {24'd0, reset_count}, 0);
    chk("midhold_async_soc",   {31'd0, soc_reset_n}, 0);
    chk("midhold_async_short", {31'd0, btn_short},   0);
    user_btn = 1'b1;
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    tick(7);
    chk("rerelease_edge7_low", {31'd0, soc_reset_n}, 0);
    tick(1);
    chk("rerelease_edge8_high", {31'd0, soc_reset_n}, 1);

    // Reset asserted mid-RUN drops soc_reset_n without waiting for an edge.
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("midrun_async_soc", {31'd0, soc_reset_n}, 0);
    chk("midrun_async_count", {24'd0, reset_count}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_reset_ctrl.md
SOC_RESET_CTRL -- requirements
Module: soc_reset_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles for the button to be accepted (10 ms at 50 MHz).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 1024: minimum soc_reset_n low time with the button released.
REQ-004 The block SHALL have parameter LONG_PRESS_CYCLES, default 100000000: press length that forces a reset when RESET_CTRL_LONG_PRESS_EN is defined.
REQ-005 The block SHALL have port clk_clk, input, 1 bit: 50 MHz system clock.
REQ-006 The block SHALL have port reset_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port user_btn, input, 1 bit: raw, asynchronous, bouncing push-button, where 0 means pressed.
REQ-008 The block SHALL have port soc_reset_n, output, 1 bit: registered active-low reset to the SoC core.
REQ-009 The block SHALL have port btn_short, output, 1 bit: one-cycle pulse on a short press, tied 0 without the macro.
REQ-010 The block SHALL have port reset_count, output, 8 bits: number of button-initiated resets, saturating.

Function
REQ-011 user_btn SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Debouncer: while the synchronized value differs from btn_db, a counter increments; on any cycle where they are equal, the counter clears.
REQ-013 When the debounce counter reaches DEBOUNCE_CYCLES-1 while the values still differ, btn_db SHALL take the synchronized value and the counter SHALL clear.
REQ-014 Any bounce shorter than DEBOUNCE_CYCLES SHALL NOT change btn_db.
REQ-015 The FSM SHALL have states HOLD, RUN and PRESS; PRESS exists only with the macro.
REQ-016 HOLD: soc_reset_n=0; hold counter increments each cycle btn_db=1 and clears each cycle btn_db=0; at HOLD_CYCLES-1 the FSM SHALL go to RUN.
REQ-017 RUN: soc_reset_n=1; a btn_db 1->0 transition SHALL leave RUN (see Configuration).
REQ-018 soc_reset_n SHALL be registered from the next state: high iff the next state is RUN or PRESS, with no combinational path from any input.
REQ-019 Pin-press-to-soc_reset_n-low latency SHALL be exactly DEBOUNCE_CYCLES+3 clock edges (2 sync, DEBOUNCE_CYCLES debounce, 1 FSM) for a clean press.
REQ-020 reset_count SHALL increment by 1 on each RUN->HOLD or PRESS->HOLD transition and SHALL hold at 255 (no wrap).
REQ-021 A button held continuously SHALL keep the FSM in HOLD indefinitely; release restarts the HOLD_CYCLES count from 0.
REQ-022 Hold and debounce counters SHALL be sized by $clog2 of their parameter and SHALL NOT overflow for any parameter value >= 2.

Reset
REQ-023 On reset_reset_n=0, the block SHALL asynchronously set: state=HOLD, soc_reset_n=0, btn_short=0, reset_count=0, btn_db=1, sync flops=1, all counters=0.
REQ-024 Assertion mid-operation, including mid-HOLD or mid-PRESS, SHALL abort immediately to the REQ-023 values.
REQ-025 After release, the block SHALL run a full HOLD sequence; with the button released, soc_reset_n rises on the HOLD_CYCLES-th clock edge after release.

Configuration
REQ-026 Macro RESET_CTRL_LONG_PRESS_EN undefined: a press in RUN SHALL go directly to HOLD; PRESS logic is absent; btn_short is constant 0.
REQ-027 Macro defined: a press in RUN SHALL go to PRESS (soc_reset_n stays 1) with the press counter cleared.
REQ-028 Macro defined, release before LONG_PRESS_CYCLES: btn_short SHALL pulse high for 1 cycle and the FSM SHALL return to RUN.
REQ-029 Macro defined, counter reaches LONG_PRESS_CYCLES-1 while pressed: the FSM SHALL go to HOLD.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, LONG_PRESS_CYCLES=16)
REQ-030 Release reset_reset_n with btn=1 -> soc_reset_n rises exactly 8 edges later; reset_count=0.
REQ-031 In RUN, btn low for 3 cycles then high -> no change; soc_reset_n stays 1; reset_count stays 0.
REQ-032 Macro off, in RUN, btn low for 20 cycles -> soc_reset_n low 7 edges after the pin falls; high 8 edges after btn_db returns to 1; reset_count=1.
REQ-033 Macro on, btn low for 10 cycles -> btn_short pulses once, soc_reset_n stays 1; btn low for 40 cycles -> reset issued, reset_count increments.
REQ-034 Force 300 button resets -> reset_count=255; assert reset_reset_n mid-HOLD -> all outputs take REQ-023 values immediately.
